// File: rtl/selection_credit.sv
// Credit-aware output selection between the odd-even routing stage and the switch allocator.
// Each input port runs its own IDLE/REQUEST/ACTIVE FSM and holds its chosen output until the tail flit leaves.
module selection_credit #(
    parameter int N        = 5,
    parameter int M        = 3,
    parameter int CREDIT_W = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [0:N-1]                  i_select_neighbor,
    input  logic [0:N-1][0:M-1][1:0]      i_avail_directions,
    input  logic [0:N-1][CREDIT_W-1:0]    i_credits,
    input  logic [0:N-1]                  i_sa_grant,
    input  logic [0:N-1]                  i_tail_sent,
    output logic [0:N-1][0:N-1]           o_sa_request,
    output logic [0:N-1][2:0]             o_out_port,
    output logic [0:N-1]                  o_busy,
    output logic [0:N-1]                  o_route_error
);

    localparam int SLOTS = M - 1;

    typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE} state_t;
    typedef logic [0:SLOTS-1][1:0] cand_t;

    state_t                   state_q [N];
    cand_t                    cand_q  [N];
    logic [1:0]               cnt_q   [N];
    logic [0:N-1][0:N-1]      req_q;
    logic [0:N-1][2:0]        outPort_q;
    logic [0:N-1]             busy_q;
    logic [0:N-1]             err_q;

    cand_t                    newCand_d [N];
    logic [2:0]               newPort_d [N];
    logic [2:0]               rePort_d  [N];
    logic                     listOk    [N];
    logic                     reselect  [N];

    // Direction code d drives output port d+1; strict '>' keeps ties on the lowest slot.
    function automatic logic [2:0] pickPort(input cand_t cand, input logic [1:0] cnt,
                                            input logic [0:N-1][CREDIT_W-1:0] cred);
        logic [2:0] best;
        logic [2:0] p;
        best = {1'b0, cand[0]} + 3'd1;
        for (int s = 1; s < SLOTS; s++) begin
            p = {1'b0, cand[s]} + 3'd1;
            if (s < int'(cnt) && cred[p] > cred[best]) begin
                best = p;
            end
        end
        return best;
    endfunction

    function automatic logic anyLive(input cand_t cand, input logic [1:0] cnt,
                                     input logic [0:N-1][CREDIT_W-1:0] cred);
        logic       live;
        logic [2:0] p;
        live = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            p = {1'b0, cand[s]} + 3'd1;
            if (s < int'(cnt) && cred[p] != '0) begin
                live = 1'b1;
            end
        end
        return live;
    endfunction

    function automatic logic [0:N-1] oneHot(input logic [2:0] port);
        logic [0:N-1] v;
        v       = '0;
        v[port] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            newCand_d[i] = '0;
            for (int s = 0; s < SLOTS; s++) begin
                if (s < int'(i_avail_directions[i][M-1])) begin
                    newCand_d[i][s] = i_avail_directions[i][s];
                end
            end
            listOk[i]    = (i_avail_directions[i][M-1] != 2'd0) &&
                           (int'(i_avail_directions[i][M-1]) <= SLOTS);
            newPort_d[i] = pickPort(newCand_d[i], i_avail_directions[i][M-1], i_credits);
            rePort_d[i]  = pickPort(cand_q[i], cnt_q[i], i_credits);
            // A stalled pending port only moves if some captured alternative actually has room.
            reselect[i]  = (i_credits[outPort_q[i]] == '0) &&
                           anyLive(cand_q[i], cnt_q[i], i_credits);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i]   <= IDLE;
                cand_q[i]    <= '0;
                cnt_q[i]     <= '0;
                req_q[i]     <= '0;
                outPort_q[i] <= '0;
                busy_q[i]    <= 1'b0;
                err_q[i]     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                err_q[i] <= 1'b0;
                case (state_q[i])
                    IDLE: begin
                        if (i_select_neighbor[i]) begin
                            if (listOk[i]) begin
                                cand_q[i]    <= newCand_d[i];
                                cnt_q[i]     <= i_avail_directions[i][M-1];
                                outPort_q[i] <= newPort_d[i];
                                req_q[i]     <= oneHot(newPort_d[i]);
                                busy_q[i]    <= 1'b1;
                                state_q[i]   <= REQUEST;
                            end else begin
                                err_q[i] <= 1'b1;
                            end
                        end
                    end
                    REQUEST: begin
                        if (i_sa_grant[i]) begin
                            req_q[i] <= '0;
                            if (i_tail_sent[i]) begin
                                outPort_q[i] <= '0;
                                busy_q[i]    <= 1'b0;
                                state_q[i]   <= IDLE;
                            end else begin
                                state_q[i] <= ACTIVE;
                            end
                        end else if (reselect[i]) begin
                            outPort_q[i] <= rePort_d[i];
                            req_q[i]     <= oneHot(rePort_d[i]);
                        end
                    end
                    ACTIVE: begin
                        if (i_tail_sent[i]) begin
                            outPort_q[i] <= '0;
                            busy_q[i]    <= 1'b0;
                            state_q[i]   <= IDLE;
                        end
                    end
                    default: begin
                        req_q[i]     <= '0;
                        outPort_q[i] <= '0;
                        busy_q[i]    <= 1'b0;
                        state_q[i]   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_sa_request  = req_q;
    assign o_out_port    = outPort_q;
    assign o_busy        = busy_q;
    assign o_route_error = err_q;

endmodule

// File: tb/tb_selection_credit.sv
// Directed bench for selection_credit: a table of one-cycle vectors plus hand sequences
// for reset mid-packet and simultaneous selects on every input.
module tb_selection_credit;

    localparam int N  = 5;
    localparam int M  = 3;
    localparam int CW = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [0:N-1]            sel;
    logic [0:N-1][0:M-1][1:0] avail;
    logic [0:N-1][CW-1:0]    credits;
    logic [0:N-1]            grant;
    logic [0:N-1]            tail;
    logic [0:N-1][0:N-1]     saRequest;
    logic [0:N-1][2:0]       outPort;
    logic [0:N-1]            busy;
    logic [0:N-1]            routeError;

    int checks = 0;
    int errors = 0;

    selection_credit #(.N(N), .M(M), .CREDIT_W(CW)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_select_neighbor  (sel),
        .i_avail_directions (avail),
        .i_credits          (credits),
        .i_sa_grant         (grant),
        .i_tail_sent        (tail),
        .o_sa_request       (saRequest),
        .o_out_port         (outPort),
        .o_busy             (busy),
        .o_route_error      (routeError)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                name;
        int                   idx;
        logic                 sel;
        logic [1:0]           d0;
        logic [1:0]           d1;
        logic [1:0]           cnt;
        logic [0:N-1][CW-1:0] cred;
        logic                 grant;
        logic                 tail;
        logic [0:N-1]         expReq;
        logic [2:0]           expPort;
        logic                 expBusy;
        logic                 expErr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [0:N-1][CW-1:0] cr(input int l, input int n, input int e,
                                                input int s, input int w);
        logic [0:N-1][CW-1:0] c;
        c[0] = CW'(l); c[1] = CW'(n); c[2] = CW'(e); c[3] = CW'(s); c[4] = CW'(w);
        return c;
    endfunction

    function automatic void add(input string name, input int idx, input logic s,
                                input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] cnt,
                                input logic [0:N-1][CW-1:0] cred, input logic g, input logic t,
                                input logic [0:N-1] eReq, input logic [2:0] ePort,
                                input logic eBusy, input logic eErr);
        vec_t v;
        v.name = name; v.idx = idx; v.sel = s; v.d0 = d0; v.d1 = d1; v.cnt = cnt;
        v.cred = cred; v.grant = g; v.tail = t;
        v.expReq = eReq; v.expPort = ePort; v.expBusy = eBusy; v.expErr = eErr;
        vecs.push_back(v);
    endfunction

    task automatic clearInputs();
        sel     = '0;
        avail   = '0;
        credits = '0;
        grant   = '0;
        tail    = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearInputs();
        sel[v.idx]      = v.sel;
        avail[v.idx][0] = v.d0;
        avail[v.idx][1] = v.d1;
        avail[v.idx][2] = v.cnt;
        credits         = v.cred;
        grant[v.idx]    = v.grant;
        tail[v.idx]     = v.tail;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Direction codes: 0=N 1=E 2=S 3=W; ports: 1=N 2=E 3=S 4=W.
        add("in2 E1 N4",      2, 1, 2'd1, 2'd0, 2'd2, cr(0,4,1,0,0), 0, 0, 5'b01000, 3'd1, 1, 0);
        add("in2 grant+tail", 2, 0, 0, 0, 0,          cr(0,4,1,0,0), 1, 1, 5'b00000, 3'd0, 0, 0);
        add("in2 tie",        2, 1, 2'd1, 2'd0, 2'd2, cr(0,4,4,0,0), 0, 0, 5'b00100, 3'd2, 1, 0);
        add("in2 grant",      2, 0, 0, 0, 0,          cr(0,4,4,0,0), 1, 0, 5'b00000, 3'd2, 1, 0);
        add("in2 tail",       2, 0, 0, 0, 0,          cr(0,4,4,0,0), 0, 1, 5'b00000, 3'd0, 0, 0);
        add("in0 sel S",      0, 1, 2'd2, 2'd0, 2'd1, cr(0,0,0,0,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in0 hold1",      0, 0, 0, 0, 0,          cr(0,5,0,0,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in0 hold2",      0, 0, 0, 0, 0,          cr(0,5,0,0,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in0 hold3",      0, 0, 0, 0, 0,          cr(0,0,0,0,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in0 hold4",      0, 0, 0, 0, 0,          cr(0,0,0,0,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in0 grant",      0, 0, 0, 0, 0,          cr(0,0,0,0,0), 1, 0, 5'b00000, 3'd3, 1, 0);
        add("in0 active1",    0, 0, 0, 0, 0,          cr(0,0,0,0,0), 0, 0, 5'b00000, 3'd3, 1, 0);
        add("in0 active2",    0, 1, 2'd1, 2'd0, 2'd1, cr(0,0,3,0,0), 1, 0, 5'b00000, 3'd3, 1, 0);
        add("in0 tail",       0, 0, 0, 0, 0,          cr(0,0,0,0,0), 0, 1, 5'b00000, 3'd0, 0, 0);
        add("in3 sel E",      3, 1, 2'd1, 2'd2, 2'd2, cr(0,0,3,1,0), 0, 0, 5'b00100, 3'd2, 1, 0);
        add("in3 reselect",   3, 0, 0, 0, 0,          cr(0,0,0,2,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in3 grant wins", 3, 0, 0, 0, 0,          cr(0,0,5,0,0), 1, 0, 5'b00000, 3'd3, 1, 0);
        add("in3 tail",       3, 0, 0, 0, 0,          cr(0,0,5,0,0), 0, 1, 5'b00000, 3'd0, 0, 0);
        add("in4 cnt0",       4, 1, 2'd1, 2'd2, 2'd0, cr(0,1,1,1,1), 0, 0, 5'b00000, 3'd0, 0, 1);
        add("in4 err drop",   4, 0, 0, 0, 0,          cr(0,1,1,1,1), 0, 0, 5'b00000, 3'd0, 0, 0);
        add("in4 cnt3",       4, 1, 2'd1, 2'd2, 2'd3, cr(0,1,1,1,1), 0, 0, 5'b00000, 3'd0, 0, 1);
        add("in4 err drop2",  4, 0, 0, 0, 0,          cr(0,1,1,1,1), 0, 0, 5'b00000, 3'd0, 0, 0);
        add("in1 sel W",      1, 1, 2'd3, 2'd0, 2'd2, cr(0,1,0,0,2), 0, 0, 5'b00001, 3'd4, 1, 0);
        add("in1 sel ignored",1, 1, 2'd1, 2'd0, 2'd1, cr(0,1,7,0,2), 0, 0, 5'b00001, 3'd4, 1, 0);
        add("in1 keep list",  1, 0, 0, 0, 0,          cr(0,3,7,0,0), 0, 0, 5'b01000, 3'd1, 1, 0);
        add("in1 grant+tail", 1, 0, 0, 0, 0,          cr(0,3,7,0,0), 1, 1, 5'b00000, 3'd0, 0, 0);
        add("in1 idle ignore",1, 0, 0, 0, 0,          cr(0,3,7,0,0), 1, 1, 5'b00000, 3'd0, 0, 0);
        add("in0 unsigned",   0, 1, 2'd0, 2'd3, 2'd2, cr(0,3,0,0,7), 0, 0, 5'b00001, 3'd4, 1, 0);
        add("in0 gt release", 0, 0, 0, 0, 0,          cr(0,3,0,0,7), 1, 1, 5'b00000, 3'd0, 0, 0);
        add("in0 all zero",   0, 1, 2'd2, 2'd1, 2'd2, cr(0,0,0,0,0), 0, 0, 5'b00010, 3'd3, 1, 0);
        add("in0 gt release2",0, 0, 0, 0, 0,          cr(0,0,0,0,0), 1, 1, 5'b00000, 3'd0, 0, 0);

        // Reset with random inputs for two cycles.
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sel     = N'($urandom);
            avail   = (N*M*2)'({$urandom, $urandom});
            credits = (N*CW)'($urandom);
            grant   = N'($urandom);
            tail    = N'($urandom);
            tick();
            checkOutput("reset req",  32'(saRequest),  32'd0);
            checkOutput("reset port", 32'(outPort),    32'd0);
            checkOutput("reset busy", 32'(busy),       32'd0);
            checkOutput("reset err",  32'(routeError), 32'd0);
        end
        reset = 1'b0;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            tick();
            checkOutput({vecs[k].name, " req"},  32'(saRequest[vecs[k].idx]),  32'(vecs[k].expReq));
            checkOutput({vecs[k].name, " port"}, 32'(outPort[vecs[k].idx]),    32'(vecs[k].expPort));
            checkOutput({vecs[k].name, " busy"}, 32'(busy[vecs[k].idx]),       32'(vecs[k].expBusy));
            checkOutput({vecs[k].name, " err"},  32'(routeError[vecs[k].idx]), 32'(vecs[k].expErr));
        end

        // Reset while input 1 is mid-packet drops the allocation.
        clearInputs();
        sel[1] = 1'b1; avail[1][0] = 2'd0; avail[1][2] = 2'd1; credits = cr(0,2,0,0,0);
        tick();
        checkOutput("in1 pre-reset port", 32'(outPort[1]), 32'd1);
        clearInputs();
        grant[1] = 1'b1;
        tick();
        checkOutput("in1 active busy", 32'(busy[1]), 32'd1);
        clearInputs();
        reset = 1'b1;
        sel[1] = 1'b1; avail[1][0] = 2'd1; avail[1][2] = 2'd1; tail[1] = 1'b0;
        tick();
        checkOutput("in1 reset busy", 32'(busy[1]),    32'd0);
        checkOutput("in1 reset port", 32'(outPort[1]), 32'd0);
        checkOutput("reset mid req",  32'(saRequest),  32'd0);
        reset = 1'b0;

        // Simultaneous selects on every input, one-slot lists.
        clearInputs();
        sel     = '1;
        credits = cr(1,1,1,1,1);
        for (int i = 0; i < N; i++) begin
            avail[i][0] = 2'(i % 4);
            avail[i][2] = 2'd1;
        end
        tick();
        for (int i = 0; i < N; i++) begin
            logic [0:N-1] hot;
            hot = '0;
            hot[(i % 4) + 1] = 1'b1;
            checkOutput($sformatf("all%0d port", i), 32'(outPort[i]),   32'((i % 4) + 1));
            checkOutput($sformatf("all%0d req", i),  32'(saRequest[i]), 32'(hot));
        end
        clearInputs();
        grant = '1;
        tail  = '1;
        tick();
        checkOutput("all idle busy", 32'(busy),      32'd0);
        checkOutput("all idle req",  32'(saRequest), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/selection_credit.md
Name: selection_credit

Overview:
- Consumer side of the routing/selection interface; one instance per router, sitting between the odd-even routing stage and the switch allocator.
- Per input port, it captures the candidate direction list when the select enable pulses. It picks the candidate output with the most downstream credits, then issues a one-hot switch-allocation request.
- It holds the chosen output until the packet's tail flit has left.

Parameters:
- N, 5, number of router ports (local, north, east, south, west).
- M, 3, candidate-list slots per input; slots 0..M-2 hold directions, slot M-1 holds the valid-candidate count.
- CREDIT_W, 3, width of each downstream credit counter value.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i_select_neighbor  input  [0:N-1]  per-input pulse: the candidate list is valid this cycle.
- i_avail_directions  input  [0:N-1][0:M-1][1:0]  candidate list; direction code 0=N, 1=E, 2=S, 3=W; slot M-1 holds the count.
- i_credits  input  [0:N-1][CREDIT_W-1:0]  free downstream buffer slots per output port (0=L, 1=N, 2=E, 3=S, 4=W).
- i_sa_grant  input  [0:N-1]  per-input grant pulse from the switch allocator.
- i_tail_sent  input  [0:N-1]  per-input pulse: tail flit crossed the crossbar.
- o_sa_request  output  [0:N-1][0:N-1]  one-hot output-port request per input.
- o_out_port  output  [0:N-1][2:0]  chosen output port index (1..4) per input.
- o_busy  output  [0:N-1]  input is not IDLE.
- o_route_error  output  [0:N-1]  one-cycle pulse on an illegal candidate list.

Behaviour:
- Independent FSM per input i with states IDLE, REQUEST, ACTIVE.
- Reset: every FSM goes to IDLE. o_sa_request, o_out_port, o_busy and o_route_error are all 0. Captured candidates are cleared.
- Reset takes priority over every other event, including mid-packet; any in-flight allocation is dropped.
- Direction code d maps to output port index d+1.
- IDLE, i_select_neighbor[i]=1:
  - Read cnt = i_avail_directions[i][M-1].
  - If cnt==0 or cnt>M-1: pulse o_route_error[i] next cycle and stay IDLE.
  - Otherwise: capture slots 0..cnt-1 and evaluate the selection rule using i_credits in this same cycle.
  - Next cycle: o_out_port[i]=chosen port, state=REQUEST. Latency from select to request is 1 cycle.
- Selection rule:
  - Choose the candidate with the maximum credit value.
  - Ties go to the lowest slot index.
  - If all candidates have 0 credits, still choose slot 0.
  - cnt==1 means no choice; slot 0 is used.
- REQUEST:
  - o_sa_request[i] is one-hot at o_out_port[i]; o_busy[i]=1.
  - Adaptive re-select: if the granted-pending port has 0 credits, another captured candidate has >0 credits, and no grant arrives this cycle, then o_out_port[i] updates next cycle to the new rule result.
  - i_sa_grant[i]=1: request drops next cycle. Next state is ACTIVE, or IDLE if i_tail_sent[i] is also 1 in the same cycle (single-flit packet).
- ACTIVE:
  - No request; o_out_port[i] is held; o_busy[i]=1.
  - i_tail_sent[i]=1: next state IDLE, and o_out_port[i] clears to 0.
- Ignored inputs:
  - i_select_neighbor[i] outside IDLE is ignored (no recapture, no error).
  - i_sa_grant[i] outside REQUEST is ignored.
  - i_tail_sent[i] in IDLE is ignored.
- Inputs are fully independent; simultaneous selects on all N inputs are each handled in 1 cycle.
- Credit comparisons are unsigned, at CREDIT_W width.
- No combinational path from any input to o_sa_request; all outputs are registered.

Test Plan:
- Reset asserted for 2 cycles with random inputs -> all outputs 0 and all FSMs IDLE. Reset is then asserted while input 1 is in ACTIVE -> next cycle input 1 is IDLE and o_out_port[1]=0.
- Input 2 select with list {E,N}, cnt=2; credits E=1, N=4 -> next cycle o_out_port[2]=1 and o_sa_request[2]=5'b01000. Rerun with E=4, N=4 -> o_out_port[2]=2 (tie goes to slot 0).
- Input 0 select {S}, cnt=1; credits S=0 -> request on port 3 held until a grant 5 cycles later. Request drops the next cycle, state ACTIVE. Tail pulse 3 cycles later -> IDLE and o_busy[0]=0.
- Input 3 in REQUEST on E with candidates {E,S}; credits E=0, S=2, no grant -> next cycle o_out_port[3]=3 and the request moves to bit 3.
- Input 4 select with cnt=0, then separately with cnt=3 -> o_route_error[4] pulses 1 cycle each time, state stays IDLE, no request.
- Grant and tail on the same cycle for input 1 -> IDLE next cycle. A select arriving during REQUEST is ignored, and the captured list is unchanged.
